ex_muldiv: RTL and testbench
============================

# ex_muldiv

Iterative RV32M multiply/divide unit in the EX stage. It consumes the instruction and forwarded operands held in the ID/EX pipeline register. While an M-extension operation is in flight, it raises a stall request to the hazard unit. When the result is ready, it presents a 32-bit result for the EX/MEM register. Non-M instructions pass through untouched: stall stays low and the ALU result path is used.

## Interface
Parameters:
- `XLEN`, 32, operand and result width. Only 32 is supported.

Ports:
- `clk`: in, 1, pipeline clock.
- `rstn`: in, 1, active-low reset. Reset is asynchronous; there is one clock.
- `flush`: in, 1, kills the in-flight operation (branch or exception flush of EX).
- `ir_EX`: in, 32, instruction currently in EX.
- `op_a`: in, 32, forwarded rs1 value.
- `op_b`: in, 32, forwarded rs2 value.
- `stall_o`: out, 1, holds IF/ID and ID/EX and bubbles EX/MEM while high.
- `result_valid`: out, 1, `result` is valid this cycle. The EX/MEM mux selects `result` when high.
- `result`: out, 32, M-operation result.
- `is_m`: out, 1, combinational decode. High when opcode = 7'b0110011 and funct7 = 7'b0000001.

## Operation
- FSM states are IDLE, MUL, DIV and DONE. Reset puts the FSM in IDLE and clears all registers. After reset, `stall_o`, `result_valid` and `result` are 0.
- IDLE, `is_m`=0: `stall_o`=0 and the state stays IDLE.
- IDLE, `is_m`=1: `stall_o`=1. The unit latches `op_a`, `op_b` and funct3. The next state depends on funct3:
  - funct3 0–3 (MUL, MULH, MULHSU, MULHU): next state is MUL.
  - funct3 4–7 with `op_b`=0: the special result is latched and the next state is DONE.
  - funct3 4–7 where DIV/REM has `op_a`=32'h8000_0000 and `op_b`=32'hFFFF_FFFF: the special result is latched and the next state is DONE.
  - funct3 4–7 otherwise: the magnitudes are loaded, the count is cleared and the next state is DIV.
- MUL: `stall_o`=1. The unit forms the 64-bit product of the operands, sign-extending or zero-extending each per funct3 to 33 bits. It registers the low word for MUL and the high word otherwise, then moves to DONE.
- DIV: `stall_o`=1. Each cycle performs one restoring step: shift the remainder/quotient pair left by 1, subtract the divisor, and keep the difference if it is non-negative. A 5-bit count increments each cycle. After count 31 the state moves to DONE.
- DONE: `stall_o`=0 and `result_valid`=1.
  - For signed DIV, the quotient is negated when the operand signs differ.
  - For signed REM, the remainder takes the sign of the dividend.
  - The next state is IDLE. The pipeline advances at this edge.
- Special results:
  - Divide by zero: quotient = 32'hFFFF_FFFF, remainder = `op_a`.
  - Signed overflow: quotient = 32'h8000_0000, remainder = 0.
- `flush`=1 in any state forces IDLE on the next edge and drops `stall_o` combinationally. A flush in DONE is harmless. In IDLE, flush blocks a start.
- Upstream holds `ir_EX`, `op_a` and `op_b` stable while `stall_o`=1. The unit uses only its latched copies after the IDLE cycle.

## Timing
- Multiply: 3 cycles in EX (IDLE, MUL, DONE), 2 stall cycles.
- Regular divide: 34 cycles in EX (IDLE, 32×DIV, DONE), 33 stall cycles.
- Special-case divide: 2 cycles in EX, 1 stall cycle.
- `stall_o` is a combinational function of the state, `is_m` and `flush`. It must settle before the clock edge; it is on the hazard-unit timing path.
- Back-to-back M operations: DONE returns to IDLE, and the next instruction starts on the following cycle. There is no lost cycle beyond the IDLE start cycle.
- `rstn` asserted mid-operation aborts immediately: IDLE, outputs 0.

## Structure
- Shared package `rv32m_pkg` holds:
  - the opcode and funct7 constants;
  - the funct3 encodings MUL=0, MULH=1, MULHSU=2, MULHU=3, DIV=4, DIVU=5, REM=6, REMU=7;
  - the FSM state enumeration.
- One sub-module, `ex_div_core`, contains the restoring-division datapath: remainder, quotient and divisor registers plus the count. It exposes `load`, `step` and `last` signals. The FSM, sign handling and multiply stay in `ex_muldiv`.

## Test plan
- MUL, `op_a`=7, `op_b`=-3: `stall_o` high for 2 cycles, then `result`=32'hFFFF_FFEB with `result_valid`=1.
- MULHU, `op_a`=32'hFFFF_FFFF, `op_b`=32'hFFFF_FFFF: `result`=32'hFFFF_FFFE.
- MULHSU, `op_a`=-1, `op_b`=2: `result`=32'hFFFF_FFFF.
- DIV, `op_a`=-7, `op_b`=2: 33 stall cycles, `result`=32'hFFFF_FFFD. REM with the same operands gives `result`=32'hFFFF_FFFF.
- DIVU, `op_b`=0, `op_a`=5: 1 stall cycle, `result`=32'hFFFF_FFFF. REMU with the same operands gives `result`=5.
- DIV, `op_a`=32'h8000_0000, `op_b`=-1: `result`=32'h8000_0000. REM with the same operands gives 0.
- DIV started, `flush` pulsed at DIV cycle 10: `stall_o` low in the flush cycle, IDLE next cycle. A following ADD shows `stall_o`=0 and `result_valid`=0.
- `rstn` pulsed during MUL: all outputs 0 immediately. A fresh MUL afterwards completes normally.

Source files
------------

// File: rtl/rv32m_pkg.sv
// Shared RV32M decode constants, funct3 encodings and muldiv FSM states.
package rv32m_pkg;

    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    localparam logic [2:0] F3_MUL    = 3'd0;
    localparam logic [2:0] F3_MULH   = 3'd1;
    localparam logic [2:0] F3_MULHSU = 3'd2;
    localparam logic [2:0] F3_MULHU  = 3'd3;
    localparam logic [2:0] F3_DIV    = 3'd4;
    localparam logic [2:0] F3_DIVU   = 3'd5;
    localparam logic [2:0] F3_REM    = 3'd6;
    localparam logic [2:0] F3_REMU   = 3'd7;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    function automatic logic f3_is_mul(input logic [2:0] f3);
        return f3 inside {F3_MUL, F3_MULH, F3_MULHSU, F3_MULHU};
    endfunction

    function automatic logic f3_is_rem(input logic [2:0] f3);
        return f3 inside {F3_REM, F3_REMU};
    endfunction

    function automatic logic f3_div_signed(input logic [2:0] f3);
        return !(f3 inside {F3_DIVU, F3_REMU});
    endfunction

    // Operand sign-extension before the 33x33 multiply
    function automatic logic f3_a_signed(input logic [2:0] f3);
        return f3 inside {F3_MUL, F3_MULH, F3_MULHSU};
    endfunction

    function automatic logic f3_b_signed(input logic [2:0] f3);
        return f3 inside {F3_MUL, F3_MULH};
    endfunction

endpackage

// File: rtl/ex_div_core.sv
// Restoring unsigned divider: one quotient bit per step, XLEN steps per divide.
module ex_div_core
    import rv32m_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            load,
    input  logic            step,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic            last,
    output logic [XLEN-1:0] quo_nxt_c,
    output logic [XLEN-1:0] rem_nxt_c
);

    localparam int unsigned CW = $clog2(XLEN);

    logic [XLEN-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XLEN:0]   trial;
    logic [XLEN+1:0] diff;
    logic            unused_diff_bit;

    // Shift in the next dividend bit and try to subtract the divisor
    always_comb begin
        trial = {rem_q, quo_q[XLEN-1]};
        diff  = {1'b0, trial} - {2'b00, dvs_q};
        if (diff[XLEN+1]) begin
            rem_nxt_c = trial[XLEN-1:0];
            quo_nxt_c = {quo_q[XLEN-2:0], 1'b0};
        end else begin
            rem_nxt_c = diff[XLEN-1:0];
            quo_nxt_c = {quo_q[XLEN-2:0], 1'b1};
        end
    end

    // A kept difference is always below the divisor, so its top bit is zero
    assign unused_diff_bit = diff[XLEN];
    assign last            = (cnt_q == CW'(XLEN-1));

    always_comb begin
        rem_d = rem_q;
        quo_d = quo_q;
        dvs_d = dvs_q;
        cnt_d = cnt_q;
        if (load) begin
            rem_d = '0;
            quo_d = dividend;
            dvs_d = divisor;
            cnt_d = '0;
        end else if (step) begin
            rem_d = rem_nxt_c;
            quo_d = quo_nxt_c;
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
            cnt_q <= '0;
        end else begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            dvs_q <= dvs_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/ex_muldiv.sv
// EX-stage iterative RV32M unit: 1-cycle multiply, 32-step divide, stall to hazard unit.
module ex_muldiv
    import rv32m_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            flush,
    input  logic [31:0]     ir_EX,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            stall_o,
    output logic            result_valid,
    output logic [XLEN-1:0] result,
    output logic            is_m
);

    localparam int unsigned PW = 2*XLEN + 2;
    localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

    logic [1:0]      state_q, state_d;
    logic [XLEN-1:0] a_q, a_d, b_q, b_d, result_q, result_d;
    logic [2:0]      f3_q, f3_d;
    logic            valid_q, valid_d;

    logic [2:0]      f3;
    logic            div_load, div_step, div_last;
    logic [XLEN-1:0] dvd_mag, dvs_mag, quo_nxt, rem_nxt;
    logic [PW-1:0]   mul_a, mul_b, prod;
    logic            unused_ok;

    assign f3   = ir_EX[14:12];
    assign is_m = (ir_EX[6:0] == OPC_OP) && (ir_EX[31:25] == F7_MULDIV);

    assign dvd_mag = (f3_div_signed(f3) && op_a[XLEN-1]) ? -op_a : op_a;
    assign dvs_mag = (f3_div_signed(f3) && op_b[XLEN-1]) ? -op_b : op_b;

    // Low PW bits of the product are exact for any mix of signed/unsigned operands
    assign mul_a = {{(XLEN+2){f3_a_signed(f3_q) & a_q[XLEN-1]}}, a_q};
    assign mul_b = {{(XLEN+2){f3_b_signed(f3_q) & b_q[XLEN-1]}}, b_q};
    assign prod  = mul_a * mul_b;

    assign unused_ok = ^{ir_EX[24:15], ir_EX[11:7], prod[PW-1:2*XLEN]};

    ex_div_core #(.XLEN(XLEN)) u_div (
        .clk       (clk),
        .rstn      (rstn),
        .load      (div_load),
        .step      (div_step),
        .dividend  (dvd_mag),
        .divisor   (dvs_mag),
        .last      (div_last),
        .quo_nxt_c (quo_nxt),
        .rem_nxt_c (rem_nxt)
    );

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        f3_d     = f3_q;
        result_d = '0;
        stall_o  = 1'b0;
        div_load = 1'b0;
        div_step = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (is_m) begin
                    stall_o = 1'b1;
                    a_d     = op_a;
                    b_d     = op_b;
                    f3_d    = f3;
                    if (f3_is_mul(f3)) begin
                        state_d = S_MUL;
                    end else if (op_b == '0) begin
                        result_d = f3_is_rem(f3) ? op_a : '1;
                        state_d  = S_DONE;
                    end else if (f3_div_signed(f3) && op_a == SMIN && op_b == '1) begin
                        result_d = f3_is_rem(f3) ? '0 : SMIN;
                        state_d  = S_DONE;
                    end else begin
                        div_load = 1'b1;
                        state_d  = S_DIV;
                    end
                end
            end
            S_MUL: begin
                stall_o  = 1'b1;
                result_d = (f3_q == F3_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
                state_d  = S_DONE;
            end
            S_DIV: begin
                stall_o  = 1'b1;
                div_step = 1'b1;
                // Sign fix-up applied to the final step's outputs so DONE shows the answer
                if (div_last) begin
                    state_d = S_DONE;
                    if (f3_is_rem(f3_q))
                        result_d = (f3_div_signed(f3_q) && a_q[XLEN-1]) ? -rem_nxt : rem_nxt;
                    else
                        result_d = (f3_div_signed(f3_q) && (a_q[XLEN-1] ^ b_q[XLEN-1]))
                                   ? -quo_nxt : quo_nxt;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (flush) begin
            state_d  = S_IDLE;
            result_d = '0;
            stall_o  = 1'b0;
            div_load = 1'b0;
            div_step = 1'b0;
        end
        if (!rstn) begin
            stall_o = 1'b0;
        end

        valid_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            f3_q     <= '0;
            result_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            f3_q     <= f3_d;
            result_q <= result_d;
            valid_q  <= valid_d;
        end
    end

    assign result_valid = valid_q;
    assign result       = result_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed bench for ex_muldiv with a cycle-level behavioural reference model.
module tb_ex_muldiv;

    logic        clk = 1'b0;
    logic        rstn;
    logic        flush;
    logic [31:0] ir_EX, op_a, op_b;
    logic        stall_o, result_valid, is_m;
    logic [31:0] result;

    int passed = 0;
    int total  = 0;

    ex_muldiv #(.XLEN(32)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .flush        (flush),
        .ir_EX        (ir_EX),
        .op_a         (op_a),
        .op_b         (op_b),
        .stall_o      (stall_o),
        .result_valid (result_valid),
        .result       (result),
        .is_m         (is_m)
    );

    always #5 clk = ~clk;

    localparam logic [31:0] ADD = {7'b0000000, 5'd2, 5'd1, 3'b000, 5'd3, 7'b0110011};

    function automatic logic [31:0] mk_m(input logic [2:0] f3);
        return {7'b0000001, 5'd2, 5'd1, f3, 5'd3, 7'b0110011};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Reference results straight from the RV32M definitions, using 64-bit arithmetic
    function automatic logic [31:0] model_res(input logic [2:0] f3, input logic [31:0] a,
                                              input logic [31:0] b);
        longint          p;
        longint unsigned pu;
        logic            ovf;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (f3)
            3'd0: begin p = longint'($signed(a)) * longint'($signed(b)); return p[31:0]; end
            3'd1: begin p = longint'($signed(a)) * longint'($signed(b)); return p[63:32]; end
            3'd2: begin p = longint'($signed(a)) * longint'({32'd0, b}); return p[63:32]; end
            3'd3: begin pu = {32'd0, a} * {32'd0, b}; return pu[63:32]; end
            3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000
                                  : 32'($signed(a) / $signed(b));
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: return (b == 0) ? a : ovf ? 32'd0 : 32'($signed(a) % $signed(b));
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int model_stalls(input logic [2:0] f3, input logic [31:0] a,
                                        input logic [31:0] b);
        if (!f3[2]) return 2;
        if (b == 0) return 1;
        if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    // Cycle-level model: remaining stall cycles, then one result cycle
    int          m_stall = 0;
    bit          m_done  = 0;
    logic [31:0] m_res   = '0;

    always @(negedge clk) begin
        logic exp_stall, exp_valid, exp_ism;
        exp_ism = (ir_EX[6:0] == 7'b0110011) && (ir_EX[31:25] == 7'b0000001);
        if (!rstn) begin
            m_stall = 0;
            m_done  = 0;
            check("rst_stall", {31'd0, stall_o}, 32'd0);
            check("rst_valid", {31'd0, result_valid}, 32'd0);
            check("rst_result", result, 32'd0);
        end else begin
            exp_valid = 1'b0;
            if (m_done) begin
                exp_stall = 1'b0;
                exp_valid = 1'b1;
                m_done    = 0;
            end else if (m_stall > 0) begin
                exp_stall = !flush;
                if (flush) m_stall = 0;
                else begin
                    m_stall--;
                    if (m_stall == 0) m_done = 1;
                end
            end else begin
                exp_stall = exp_ism && !flush;
                if (exp_stall) begin
                    m_res   = model_res(ir_EX[14:12], op_a, op_b);
                    m_stall = model_stalls(ir_EX[14:12], op_a, op_b) - 1;
                    if (m_stall == 0) m_done = 1;
                end
            end
            check("cmp_is_m", {31'd0, is_m}, {31'd0, exp_ism});
            check("cmp_stall", {31'd0, stall_o}, {31'd0, exp_stall});
            check("cmp_valid", {31'd0, result_valid}, {31'd0, exp_valid});
            if (exp_valid) check("cmp_result", result, m_res);
        end
    end

    // Issue one M instruction on the next cycle and wait for its result
    task automatic run_op(input string name, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_r, input int exp_st);
        int  n;
        bit  done;
        @(posedge clk); #1;
        ir_EX = mk_m(f3);
        op_a  = a;
        op_b  = b;
        n     = 0;
        done  = 0;
        for (int k = 0; k < 100 && !done; k++) begin
            @(negedge clk);
            if (stall_o) n++;
            else done = 1;
        end
        if (!done) check({name, "_timeout"}, 32'd0, 32'd1);
        check({name, "_stalls"}, 32'(n), 32'(exp_st));
        check({name, "_valid"}, {31'd0, result_valid}, 32'd1);
        check({name, "_result"}, result, exp_r);
    endtask

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a, b, r;
        int          st;
    } vec_t;

    vec_t vecs[15];

    initial begin
        vecs[0]  = '{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 2};
        vecs[1]  = '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 2};
        vecs[2]  = '{3'd2, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF, 2};
        vecs[3]  = '{3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 33};
        vecs[4]  = '{3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 33};
        vecs[5]  = '{3'd5, 32'd5,          32'd0,         32'hFFFF_FFFF, 1};
        vecs[6]  = '{3'd7, 32'd5,          32'd0,         32'd5,         1};
        vecs[7]  = '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1};
        vecs[8]  = '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1};
        vecs[9]  = '{3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 2};
        vecs[10] = '{3'd5, 32'hFFFF_FFFF,  32'd3,         32'h5555_5555, 33};
        vecs[11] = '{3'd7, 32'd100,        32'd7,         32'd2,         33};
        vecs[12] = '{3'd4, 32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD, 33};
        vecs[13] = '{3'd6, 32'd7,          32'hFFFF_FFFE, 32'd1,         33};
        vecs[14] = '{3'd6, 32'hFFFF_FFF7,  32'd0,         32'hFFFF_FFF7, 1};

        rstn  = 1'b0;
        flush = 1'b0;
        ir_EX = ADD;
        op_a  = '0;
        op_b  = '0;
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;

        for (int i = 0; i < 15; i++)
            run_op($sformatf("vec%0d", i), vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].r, vecs[i].st);

        // Flush during the tenth divide step, then a plain ADD
        @(posedge clk); #1;
        ir_EX = mk_m(3'd4);
        op_a  = 32'hFFFF_FFF9;
        op_b  = 32'd2;
        @(negedge clk);
        check("flush_start_stall", {31'd0, stall_o}, 32'd1);
        repeat (10) @(posedge clk);
        #1 flush = 1'b1;
        @(negedge clk);
        check("flush_cycle_stall", {31'd0, stall_o}, 32'd0);
        @(posedge clk); #1;
        flush = 1'b0;
        ir_EX = ADD;
        @(negedge clk);
        check("flush_add_stall", {31'd0, stall_o}, 32'd0);
        check("flush_add_valid", {31'd0, result_valid}, 32'd0);

        // Reset pulsed while in the MUL state
        @(posedge clk); #1;
        ir_EX = mk_m(3'd0);
        op_a  = 32'd6;
        op_b  = 32'd7;
        @(posedge clk); #1;
        check("pre_rst_stall", {31'd0, stall_o}, 32'd1);
        rstn = 1'b0;
        #1;
        check("mid_rst_stall", {31'd0, stall_o}, 32'd0);
        check("mid_rst_valid", {31'd0, result_valid}, 32'd0);
        check("mid_rst_result", result, 32'd0);
        ir_EX = ADD;
        @(posedge clk); #1 rstn = 1'b1;
        run_op("post_rst_mul", 3'd0, 32'd6, 32'd7, 32'd42, 2);

        @(posedge clk); #1 ir_EX = ADD;
        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
